// File: rtl/mac_package.sv
// Shared types for the requantization stage: control/flag bundles and FSM state encoding.
package mac_package;

  localparam int unsigned MAC_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic                 enable;
    logic                 clear;
    logic                 start;
    logic [MAC_CNT_W-1:0] len;
    logic [4:0]           shift;
    logic [5:0]           out_bits;
  } ctrl_requant_t;

  typedef struct packed {
    state_e               state;
    logic [MAC_CNT_W-1:0] cnt;
    logic                 sat;
    logic                 done;
  } flags_requant_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready stream interface with byte strobes.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/mac_requant_clip.sv
// Stateless shift / optional round / clip datapath.
// MAC_REQUANT_ROUND_EN adds round-half-up before the shift; otherwise the shift truncates.
module mac_requant_clip #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [4:0]            shift_i,
  input  logic [5:0]            out_bits_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sat_o
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W:0] ONE = (W+1)'(1);

  logic signed [W:0] ext, sum, shifted, lim_hi, lim_lo, clipped;
  logic        [W:0] lim_pow;
  int unsigned       ob;
  logic              unused_top;

  // One guard bit so the rounding add can never wrap.
  assign ext = $signed({data_i[W-1], data_i});

`ifdef MAC_REQUANT_ROUND_EN
  logic [W:0] rnd;
  assign rnd = (shift_i == 5'd0) ? '0 : (ONE << (shift_i - 5'd1));
  assign sum = ext + $signed(rnd);
`else
  assign sum = ext;
`endif

  assign shifted = sum >>> shift_i;

  always_comb begin
    ob = 32'(out_bits_i);
    if (ob == 0)      ob = 1;
    else if (ob > W)  ob = W;
  end

  assign lim_pow = ONE << (ob - 1);
  assign lim_hi  = $signed(lim_pow - ONE);
  assign lim_lo  = -$signed(lim_pow);

  always_comb begin
    clipped = shifted;
    sat_o   = 1'b0;
    if (shifted > lim_hi) begin
      clipped = lim_hi;
      sat_o   = 1'b1;
    end else if (shifted < lim_lo) begin
      clipped = lim_lo;
      sat_o   = 1'b1;
    end
  end

  // Clipped value always fits in W bits, so the guard bit is redundant here.
  assign data_o     = clipped[W-1:0];
  assign unused_top = clipped[W];

endmodule

// File: rtl/mac_requant.sv
// Requantization stage: stream in accumulator results, shift/clip, stream out one per cycle.
// Optional rounding selected by MAC_REQUANT_ROUND_EN (see mac_requant_clip).
module mac_requant
  import mac_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  hwpe_stream_intf_stream.sink   d_i,
  hwpe_stream_intf_stream.source q_o,
  input  ctrl_requant_t          ctrl_i,
  output flags_requant_t         flags_o
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic                  r_valid_q, r_valid_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sat_q, sat_d;

  logic                  en, len_zero, d_ready, q_valid, d_hs, q_hs, clip_sat;
  logic [CNT_WIDTH-1:0]  len_c;
  logic [DATA_WIDTH-1:0] clip_data;
  logic                  unused_strb;

  mac_requant_clip #(.DATA_WIDTH(DATA_WIDTH)) u_clip (
    .data_i     (d_i.data),
    .shift_i    (ctrl_i.shift),
    .out_bits_i (ctrl_i.out_bits),
    .data_o     (clip_data),
    .sat_o      (clip_sat)
  );

  assign en       = ctrl_i.enable;
  assign len_c    = CNT_WIDTH'(ctrl_i.len);
  assign len_zero = (len_c == '0);

  // A zero-length job must not swallow a word during its single RUN cycle.
  assign d_ready = en & (state_q == RUN) & ~len_zero & (q_o.ready | ~r_valid_q);
  assign q_valid = r_valid_q & en;
  assign d_hs    = d_i.valid & d_ready;
  assign q_hs    = q_valid & q_o.ready;

  assign d_i.ready   = d_ready;
  assign q_o.valid   = q_valid;
  assign q_o.data    = r_q;
  assign q_o.strb    = '1;
  assign unused_strb = ^d_i.strb;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    r_valid_d = r_valid_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    if (en) begin
      if (ctrl_i.clear) begin
        state_d   = IDLE;
        r_d       = '0;
        r_valid_d = 1'b0;
        cnt_d     = '0;
        sat_d     = 1'b0;
      end else begin
        case (state_q)
          IDLE: if (ctrl_i.start) begin
            state_d = RUN;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
          RUN: begin
            if (len_zero || (q_hs && (cnt_q + CNT_WIDTH'(1) == len_c))) state_d = DONE;
            if (q_hs) cnt_d = cnt_q + CNT_WIDTH'(1);
          end
          DONE:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
        // A concurrent load keeps r_valid high for back-to-back throughput.
        if (d_hs) begin
          r_d       = clip_data;
          r_valid_d = 1'b1;
          if (clip_sat) sat_d = 1'b1;
        end else if (q_hs) begin
          r_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      r_q       <= '0;
      r_valid_q <= 1'b0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      r_valid_q <= r_valid_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign flags_o.state = state_q;
  assign flags_o.cnt   = MAC_CNT_W'(cnt_q);
  assign flags_o.sat   = sat_q;
  assign flags_o.done  = (state_q == DONE) & en;

endmodule

// File: tb/tb_mac_requant.sv
// Scoreboard bench for mac_requant: directed jobs push expected words, a negedge monitor checks them.
module tb_mac_requant;
  import mac_package::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) d_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) q_if ();
  ctrl_requant_t  ctrl;
  flags_requant_t flags;

  mac_requant #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .d_i     (d_if),
    .q_o     (q_if),
    .ctrl_i  (ctrl),
    .flags_o (flags)
  );

  int          checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  int          done_n = 0, hs_n = 0, first_hs = -1, last_hs = -1, cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  bit          sent = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall && q_if.valid) chk("stall_hold", q_if.data, prev_data);
      if (q_if.valid) chk("strb", 32'(q_if.strb), 32'hf);
      if (q_if.valid && q_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got 0x%08h expected nothing", q_if.data);
        end else begin
          chk("q_data", q_if.data, exp_q.pop_front());
        end
        hs_n++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      if (flags.done) done_n++;
      prev_stall = q_if.valid && !q_if.ready;
      prev_data  = q_if.data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job(input int len, input int sh, input int ob);
    ctrl.len = 16'(len); ctrl.shift = 5'(sh); ctrl.out_bits = 6'(ob);
    ctrl.start = 1'b1;
    tick();
    ctrl.start = 1'b0;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] e);
    logic got;
    got = 1'b0;
    exp_q.push_back(e);
    d_if.valid = 1'b1;
    d_if.data  = x;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = d_if.ready;
      tick();
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no ready expected ready for 0x%08h", x);
      void'(exp_q.pop_back());
    end
    d_if.valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (flags.state == IDLE && exp_q.size() == 0) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got state %0d queue %0d expected IDLE and empty", nm, flags.state, exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d0;
    bit ok;
    rst = 1'b1;
    ctrl = '0; ctrl.enable = 1'b1;
    d_if.valid = 1'b0; d_if.data = '0; d_if.strb = '1;
    q_if.ready = 1'b1;
    repeat (3) tick();
    chk("rst_state", 32'(flags.state), 32'(IDLE));
    chk("rst_qvalid", 32'(q_if.valid), 0);
    chk("rst_dready", 32'(d_if.ready), 0);
    chk("rst_cnt", 32'(flags.cnt), 0);
    chk("rst_sat", 32'(flags.sat), 0);
    chk("rst_done", 32'(flags.done), 0);
    rst = 1'b0;
    tick();

    // shift 4, 8-bit output
    d0 = done_n;
    start_job(3, 4, 8);
    chk("a_run", 32'(flags.state), 32'(RUN));
    send(32'h100, 32'h10); send(32'h120, 32'h12); send(32'h7f0, 32'h7f);
    wait_idle("a_idle");
    chk("a_sat", 32'(flags.sat), 0);
    chk("a_cnt", 32'(flags.cnt), 3);
    chk("a_done", 32'(done_n - d0), 1);

    // saturation at both rails
    start_job(2, 0, 8);
    send(32'd300, 32'd127); send(-32'sd300, 32'hffffff80);
    wait_idle("b_idle");
    chk("b_sat", 32'(flags.sat), 1);

    // rounding vs truncation on odd values
    start_job(2, 1, 8);
`ifdef MAC_REQUANT_ROUND_EN
    send(32'd3, 32'd2); send(-32'sd3, 32'hffffffff);
`else
    send(32'd3, 32'd1); send(-32'sd3, 32'hfffffffe);
`endif
    wait_idle("c_idle");
    chk("c_sat_cleared", 32'(flags.sat), 0);

    // output backpressure 1,0,0,1
    d0 = done_n; sent = 0;
    start_job(4, 0, 16);
    fork
      begin send(10, 10); send(20, 20); send(30, 30); send(40, 40); sent = 1; end
      begin
        for (int i = 0; i < 200; i++) begin
          q_if.ready = (i % 4 == 0) || (i % 4 == 3);
          tick();
          if (sent && exp_q.size() == 0) break;
        end
      end
    join
    q_if.ready = 1'b1;
    wait_idle("d_idle");
    chk("d_done", 32'(done_n - d0), 1);
    chk("d_cnt", 32'(flags.cnt), 4);

    // clear mid-job, then a fresh job
    start_job(5, 0, 16);
    send(1, 1); send(2, 2);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    ctrl.clear = 1'b1; tick(); ctrl.clear = 1'b0;
    chk("e_state", 32'(flags.state), 32'(IDLE));
    chk("e_qvalid", 32'(q_if.valid), 0);
    chk("e_cnt", 32'(flags.cnt), 0);
    d0 = done_n;
    start_job(2, 0, 16);
    send(7, 7); send(8, 8);
    wait_idle("e_idle");
    chk("e_done", 32'(done_n - d0), 1);

    // zero-length job
    d0 = done_n;
    start_job(0, 0, 8);
    chk("z_run", 32'(flags.state), 32'(RUN));
    chk("z_dready", 32'(d_if.ready), 0);
    tick();
    chk("z_done_state", 32'(flags.state), 32'(DONE));
    tick();
    chk("z_idle", 32'(flags.state), 32'(IDLE));
    chk("z_done", 32'(done_n - d0), 1);
    chk("z_qvalid", 32'(q_if.valid), 0);

    // enable low freezes everything
    q_if.ready = 1'b0;
    start_job(1, 0, 8);
    send(5, 5);
    ctrl.enable = 1'b0;
    #1;
    chk("g_qvalid", 32'(q_if.valid), 0);
    chk("g_dready", 32'(d_if.ready), 0);
    repeat (3) tick();
    chk("g_state", 32'(flags.state), 32'(RUN));
    chk("g_cnt", 32'(flags.cnt), 0);
    ctrl.enable = 1'b1; q_if.ready = 1'b1;
    wait_idle("g_idle");
    chk("g_cnt_end", 32'(flags.cnt), 1);

    // full throughput burst
    hs_n = 0; first_hs = -1; last_hs = -1;
    start_job(8, 0, 16);
    for (int i = 1; i <= 8; i++) send(32'(100 * i), 32'(100 * i));
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      if (hs_n >= 8) begin ok = 1; break; end
      tick();
    end
    chk("f_all_out", 32'(ok), 1);
    chk("f_done_state", 32'(flags.state), 32'(DONE));
    chk("f_hs_n", 32'(hs_n), 8);
    chk("f_span", 32'(last_hs - first_hs), 7);
    wait_idle("f_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
